can_btiming: RTL and testbench

- Parametrised CAN bit-timing engine. It is the next generation of the single-counter quanta sampler.
- Adds a time-quantum prescaler and a SYNC/TSEG1/TSEG2 segment FSM.
- Adds hard synchronisation, SJW-limited resynchronisation and optional triple sampling.
- Sits between the pin-level open-drain CAN driver and the bit-stream MAC. It supplies received bits, a bit-error flag and bit-start strobes.

---
 rtl/can_btiming_if.sv | 27 ++
 rtl/can_btiming.sv | 164 ++++++++++++++++
 tb/tb_can_btiming.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/can_btiming_if.sv
// CAN bit-timing bus bundle: pad-side receive/transmit levels plus MAC-side bit stream.
// Latency: none (wires only).
// Backpressure: none; every output is a level or a single-cycle strobe.
// Ports (slave = timing engine side):
//   can_rx, din, hsync_en, resync_en : into the engine
//   can_tx, dout, dout_valid, bit_err, sync : out of the engine
interface can_btiming_if;
  logic can_rx;
  logic can_tx;
  logic din;
  logic hsync_en;
  logic resync_en;
  logic dout;
  logic dout_valid;
  logic bit_err;
  logic sync;

  modport master (
    output can_rx, din, hsync_en, resync_en,
    input  can_tx, dout, dout_valid, bit_err, sync
  );

  modport slave (
    input  can_rx, din, hsync_en, resync_en,
    output can_tx, dout, dout_valid, bit_err, sync
  );
endinterface

// File: rtl/can_btiming.sv
// CAN bit-timing engine: tq prescaler, SYNC/SEG1/SEG2 FSM, hard sync, SJW resync, optional 3-sample vote.
// Latency: rx edge to SYNC entry 3 GCLK; dout_valid on the sample-point tick (sync + (1+TSEG1)*PRESC - 1).
// Backpressure: none; dout_valid and sync are single-cycle strobes the MAC must accept.
// Ports: GCLK clock, RES_N async active-low reset, bus (slave modport of can_btiming_if).
module can_btiming #(
  parameter int PRESC  = 4,
  parameter int TSEG1  = 13,
  parameter int TSEG2  = 2,
  parameter int SJW    = 1,
  parameter int TRIPLE = 0
) (
  input  logic         GCLK,
  input  logic         RES_N,
  can_btiming_if.slave bus
);
  localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int QMAX = (TSEG1 + SJW > TSEG2) ? (TSEG1 + SJW) : TSEG2;
  localparam int QW   = $clog2(QMAX + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(PRESC - 1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [QW-1:0] Q_ONE   = QW'(1);
  localparam logic [QW-1:0] Q_SEG1  = QW'(TSEG1 - 1);
  localparam logic [QW-1:0] Q_TSEG2 = QW'(TSEG2);
  localparam logic [QW-1:0] Q_SJW   = QW'(SJW);

  typedef enum logic [1:0] {ST_SYNC, ST_SEG1, ST_SEG2} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_pcnt;
  logic [QW-1:0]   r_qcnt, w_qcnt_nxt;
  logic [QW-1:0]   r_ext, w_ext;
  logic [QW-1:0]   r_shr, w_shr;
  logic            r_sync1, r_rx_s, r_rx_d;
  logic            r_start;
  logic            r_armed;
  logic            r_sync;
  logic            r_tx_bit;
  logic            r_dout;
  logic            r_bit_err;
  logic [1:0]      r_smp;

  logic w_tick, w_fe, w_hard, w_resync, w_entry, w_sample, w_maj, w_bit;

  assign w_tick   = (r_pcnt == P_LAST);
  assign w_fe     = r_rx_d & ~r_rx_s;
  assign w_hard   = w_fe & bus.hsync_en;
  assign w_resync = w_fe & bus.resync_en & r_armed & ~bus.hsync_en;

  // Vote over the two earlier SEG1-end samples and the one taken right now.
  assign w_maj = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rx_s) | (r_smp[0] & r_rx_s);
  assign w_bit = (TRIPLE != 0) ? w_maj : r_rx_s;

  // Next-state logic. Resync evaluates the phase error against the state
  // as it stands this cycle, so an edge coinciding with a segment-ending
  // tick still sees the old segment. Any SYNC entry (reset release, hard
  // sync, late-edge resync, or normal bit end) overrides the tick path.
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_ext       = r_ext;
    w_shr       = r_shr;
    w_entry     = 1'b0;
    w_sample    = 1'b0;

    if (w_resync) begin
      case (r_state)
        ST_SEG1: w_ext = (r_qcnt + Q_ONE < Q_SJW) ? (r_qcnt + Q_ONE) : Q_SJW;
        ST_SEG2: begin
          // Edge close enough to the bit end: restart the bit outright.
          if ((Q_TSEG2 - r_qcnt) <= Q_SJW) w_entry = 1'b1;
          else                             w_shr   = Q_SJW;
        end
        default: ;
      endcase
    end

    if (r_start || w_hard) w_entry = 1'b1;

    if (!w_entry && w_tick) begin
      case (r_state)
        ST_SYNC: begin
          w_state_nxt = ST_SEG1;
          w_qcnt_nxt  = '0;
        end
        ST_SEG1: begin
          if (r_qcnt == Q_SEG1 + w_ext) begin
            w_state_nxt = ST_SEG2;
            w_qcnt_nxt  = '0;
            w_sample    = 1'b1;
          end else begin
            w_qcnt_nxt = r_qcnt + Q_ONE;
          end
        end
        ST_SEG2: begin
          if (r_qcnt == Q_TSEG2 - w_shr - Q_ONE) w_entry    = 1'b1;
          else                                   w_qcnt_nxt = r_qcnt + Q_ONE;
        end
        default: w_entry = 1'b1;
      endcase
    end

    if (w_entry) begin
      w_state_nxt = ST_SYNC;
      w_qcnt_nxt  = '0;
      w_ext       = '0;
      w_shr       = '0;
    end
  end

  always_ff @(posedge GCLK or negedge RES_N) begin
    if (!RES_N) begin
      r_state <= ST_SYNC;
      r_qcnt  <= '0;
      r_ext   <= '0;
      r_shr   <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_ext   <= w_ext;
      r_shr   <= w_shr;
      r_pcnt  <= (w_entry || w_tick) ? '0 : (r_pcnt + P_ONE);
    end
  end

  always_ff @(posedge GCLK or negedge RES_N) begin
    if (!RES_N) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
      r_start   <= 1'b1;
      r_armed   <= 1'b1;
      r_sync    <= 1'b0;
      r_tx_bit  <= 1'b1;
      r_dout    <= 1'b1;
      r_bit_err <= 1'b0;
      r_smp     <= 2'b11;
    end else begin
      r_sync1 <= bus.can_rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
      // Reset release is treated as an implicit hard sync one cycle later.
      r_start <= 1'b0;
      r_sync  <= w_entry;
      if (w_entry)       r_armed <= 1'b1;
      else if (w_resync) r_armed <= 1'b0;
      // din is taken during the sync pulse cycle and drives the pad after it.
      if (r_sync) r_tx_bit <= bus.din;
      if (w_tick && (r_state == ST_SEG1) && !w_entry) r_smp <= {r_smp[0], r_rx_s};
      if (w_sample) begin
        r_dout    <= w_bit;
        r_bit_err <= w_bit ^ r_tx_bit;
      end
    end
  end

  // dout/bit_err show the fresh sample in the strobe cycle, then hold.
  assign bus.can_tx     = r_tx_bit;
  assign bus.sync       = r_sync;
  assign bus.dout_valid = w_sample;
  assign bus.dout       = w_sample ? w_bit : r_dout;
  assign bus.bit_err    = w_sample ? (w_bit ^ r_tx_bit) : r_bit_err;
endmodule

// File: tb/tb_can_btiming.sv
module tb_can_btiming;
  logic GCLK = 1'b0;
  logic RES_N;
  logic rx, din, hs, rs;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_sync = 0;

  typedef struct {
    string name;
    bit    din;
    bit    hs;
    bit    rs;
    int    f1, r1, f2, r2;   // cycle offsets after sync where can_rx falls/rises (-1 = none)
    int    len;              // expected cycles to next sync
    bit    vld;              // a sample strobe occurs in this bit
    int    vdly;             // cycles from sync to dout_valid
    bit    da;               // expected dout, single sample
    bit    db;               // expected dout, triple sample
  } vec_t;

  typedef struct { string name; int dly; } sync_exp_t;
  typedef struct { string name; int dly; bit da; bit db; bit err; } val_exp_t;

  sync_exp_t sync_q[$];
  val_exp_t  val_q[$];
  sync_exp_t se;
  val_exp_t  ve;
  vec_t      vecs[14];

  can_btiming_if ifa ();
  can_btiming_if ifb ();

  assign ifa.can_rx = rx;  assign ifb.can_rx = rx;
  assign ifa.din = din;    assign ifb.din = din;
  assign ifa.hsync_en = hs;  assign ifb.hsync_en = hs;
  assign ifa.resync_en = rs; assign ifb.resync_en = rs;

  can_btiming #(.PRESC(4), .TSEG1(13), .TSEG2(2), .SJW(1), .TRIPLE(0)) u_a (
    .GCLK(GCLK), .RES_N(RES_N), .bus(ifa)
  );
  can_btiming #(.PRESC(4), .TSEG1(13), .TSEG2(2), .SJW(1), .TRIPLE(1)) u_b (
    .GCLK(GCLK), .RES_N(RES_N), .bus(ifb)
  );

  always #5 GCLK = ~GCLK;
  always @(posedge GCLK) cyc <= cyc + 1;

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chki(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  task automatic wait_sync(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ifa.sync === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk1({nm, "_sync_seen"}, got, 1'b1);
  endtask

  // Scoreboard consumer: pops expectations as the DUT emits strobes.
  always @(negedge GCLK) begin
    if (ifa.sync === 1'b1) begin
      if (sync_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_sync: sync pulse with nothing expected (cycle %0d)", cyc);
      end else begin
        se = sync_q.pop_front();
        if (se.dly >= 0) chki({se.name, "_bit_len"}, cyc - last_sync, se.dly);
      end
      last_sync = cyc;
    end
    if (ifa.dout_valid === 1'b1) begin
      if (val_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_dout_valid: strobe with nothing expected (cycle %0d)", cyc);
      end else begin
        ve = val_q.pop_front();
        chki({ve.name, "_valid_dly"}, cyc - last_sync, ve.dly);
        chk1({ve.name, "_dout"}, ifa.dout, ve.da);
        chk1({ve.name, "_bit_err"}, ifa.bit_err, ve.err);
        chk1({ve.name, "_b_valid"}, ifb.dout_valid, 1'b1);
        chk1({ve.name, "_b_dout"}, ifb.dout, ve.db);
      end
    end
  end

  // Entered in the sync cycle of the bit; leaves in the sync cycle of the next one.
  task automatic run_row(input vec_t v);
    int maxoff;
    val_exp_t vx;
    sync_exp_t sx;
    if (v.vld) begin
      vx.name = v.name; vx.dly = v.vdly; vx.da = v.da; vx.db = v.db; vx.err = v.da ^ v.din;
      val_q.push_back(vx);
    end
    sx.name = v.name; sx.dly = v.len;
    sync_q.push_back(sx);
    din = v.din; hs = v.hs; rs = v.rs;
    maxoff = 1;
    if (v.f1 > maxoff) maxoff = v.f1;
    if (v.r1 > maxoff) maxoff = v.r1;
    if (v.f2 > maxoff) maxoff = v.f2;
    if (v.r2 > maxoff) maxoff = v.r2;
    for (int c = 0; c <= maxoff; c++) begin
      if (c > 0) tick();
      if (c == v.f1 || c == v.f2) rx = 1'b0;
      if (c == v.r1 || c == v.r2) rx = 1'b1;
      if (c == 1) chk1({v.name, "_can_tx"}, ifa.can_tx, v.din);
    end
    wait_sync(v.name);
  endtask

  task automatic check_reset_outputs(input string p);
    chk1({p, "_sync"}, ifa.sync, 1'b0);
    chk1({p, "_dout"}, ifa.dout, 1'b1);
    chk1({p, "_dout_valid"}, ifa.dout_valid, 1'b0);
    chk1({p, "_bit_err"}, ifa.bit_err, 1'b0);
    chk1({p, "_can_tx"}, ifa.can_tx, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sync_exp_t sx;
    val_exp_t  vx;
    //             name            din hs rs  f1  r1  f2  r2  len vld vdly da db
    vecs[0]  = '{"idle",          1, 0, 0, -1, -1, -1, -1, 64, 1, 55, 1, 1};
    vecs[1]  = '{"tx0",           0, 0, 0, -1, -1, -1, -1, 64, 1, 55, 1, 1};
    vecs[2]  = '{"rx0",           1, 0, 0, 10, 58, -1, -1, 64, 1, 55, 0, 0};
    vecs[3]  = '{"triple",        1, 0, 0, 52, 54, -1, -1, 64, 1, 55, 0, 1};
    vecs[4]  = '{"rs_seg1",       1, 0, 1, 11, 20, 30, 40, 68, 1, 59, 1, 1};
    vecs[5]  = '{"rs_seg2_early", 1, 0, 1, 58, 60, -1, -1, 61, 1, 55, 1, 1};
    vecs[6]  = '{"rs_seg2_late",  1, 0, 1, 60, 61, -1, -1, 63, 1, 55, 1, 1};
    vecs[7]  = '{"rs_seg2_shr",   1, 0, 1, 55, 58, -1, -1, 60, 1, 55, 1, 1};
    vecs[8]  = '{"rs_disabled",   1, 0, 0, 58, 60, -1, -1, 64, 1, 55, 1, 1};
    vecs[9]  = '{"rs_in_sync",    1, 0, 1,  0,  5, 11, 20, 64, 1, 55, 1, 1};
    vecs[10] = '{"hsync_seg1",    1, 1, 0, 30, -1, -1, -1, 33, 0,  0, 1, 1};
    vecs[11] = '{"after_hsync",   1, 0, 0, -1, 60, -1, -1, 64, 1, 55, 0, 0};
    vecs[12] = '{"hsync_seg2",    0, 1, 0, 58, -1, -1, -1, 61, 1, 55, 1, 1};
    vecs[13] = '{"after_hsync2",  1, 0, 0, -1,  2, -1, -1, 64, 1, 55, 1, 1};

    RES_N = 1'b0; rx = 1'b1; din = 1'b1; hs = 1'b0; rs = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");

    // Release: first sync pulse one cycle later; its interval is not defined.
    RES_N = 1'b1;
    sx.name = "rst_first"; sx.dly = -1;
    sync_q.push_back(sx);
    tick();
    chk1("rst_first_sync", ifa.sync, 1'b1);

    for (int i = 0; i < 14; i++) run_row(vecs[i]);

    // Reset in the middle of SEG2 with non-reset output values showing.
    vx.name = "rst_mid"; vx.dly = 55; vx.da = 1'b1; vx.db = 1'b1; vx.err = 1'b1;
    val_q.push_back(vx);
    din = 1'b0; hs = 1'b0; rs = 1'b0; rx = 1'b1;
    for (int c = 1; c <= 58; c++) tick();
    chk1("pre_rst_bit_err", ifa.bit_err, 1'b1);
    chk1("pre_rst_can_tx", ifa.can_tx, 1'b0);
    RES_N = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    din = 1'b1;
    RES_N = 1'b1;
    sx.name = "rst_mid_first"; sx.dly = -1;
    sync_q.push_back(sx);
    tick();
    chk1("rst_mid_first_sync", ifa.sync, 1'b1);
    vx.name = "post_rst"; vx.dly = 55; vx.da = 1'b1; vx.db = 1'b1; vx.err = 1'b0;
    val_q.push_back(vx);
    sx.name = "post_rst"; sx.dly = 64;
    sync_q.push_back(sx);
    tick();
    chk1("post_rst_can_tx", ifa.can_tx, 1'b1);
    wait_sync("post_rst");
    tick();
    chki("sync_queue_drained", sync_q.size(), 0);
    chki("valid_queue_drained", val_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
